// File: rtl/cache_types_pkg.sv
// Shared cache/coherence types.
// Request-bus message and arbiter state encoding.
package cache_types;

  typedef struct packed {
    logic        valid;
    logic [2:0]  cmd;
    logic [31:0] addr;
  } req_msg_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_OWN
  } arb_state_t;

endpackage

// File: rtl/coh_req_bus_arbiter_rr_picker.sv
// Round-robin picker: first set request
// scanning from ptr_i upward with wrap.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Scan N slots starting at the pointer; first hit wins.
  always_comb begin
    logic [IW-1:0] j;
    j     = '0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr_i) + k) % N);
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/coh_req_bus_arbiter.sv
// Coherence request bus arbiter: round-robin
// ownership, snoop-busy hold and watchdog.
module coh_req_bus_arbiter
  import cache_types::*;
#(
  parameter int NUM_CACHES = 4,
  parameter int ID_BITS    = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1,
  parameter int TIMEOUT    = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CACHES-1:0] bus_req,
  input  req_msg_t              bus_tx [NUM_CACHES],
  input  logic [NUM_CACHES-1:0] bus_busy,
  output logic [NUM_CACHES-1:0] bus_gnt,
  output req_msg_t              bus_msg,
  output logic [ID_BITS-1:0]    owner_id,
  output logic                  bus_active,
  output logic                  timeout_err
);

  localparam bit          WD_EN   = (TIMEOUT > 0);
  localparam logic [31:0] CNT_END = WD_EN ? 32'(TIMEOUT - 1) : 32'd0;
  localparam logic [ID_BITS-1:0] LAST_ID = ID_BITS'(NUM_CACHES - 1);

  arb_state_t              state_q;
  logic [NUM_CACHES-1:0]   gnt_q;
  logic [ID_BITS-1:0]      owner_q;
  logic [ID_BITS-1:0]      rr_ptr_q;
  logic [ID_BITS-1:0]      rr_ptr_d;
  logic [31:0]             hold_cnt_q;
  logic                    tmo_q;

  logic [NUM_CACHES-1:0]   pick_gnt;
  logic [ID_BITS-1:0]      pick_idx;
  logic                    pick_any;
  logic                    hold;
  logic                    expire;

  rr_picker #(
    .N  (NUM_CACHES),
    .IW (ID_BITS)
  ) u_pick (
    .req_i (bus_req),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Hold while owner requests or any snooper stalls; watchdog end check.
  always_comb begin
    hold     = bus_req[owner_q] | (|bus_busy);
    expire   = WD_EN && (hold_cnt_q == CNT_END);
    rr_ptr_d = (owner_q == LAST_ID) ? '0 : owner_q + ID_BITS'(1);
  end

  // Arbitration FSM with registered grant, owner and watchdog state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      tmo_q      <= 1'b0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          hold_cnt_q <= '0;
          if (pick_any) begin
            gnt_q   <= pick_gnt;
            owner_q <= pick_idx;
            state_q <= ARB_OWN;
          end
        end
        ARB_OWN: begin
          hold_cnt_q <= hold_cnt_q + 32'd1;
          if (!hold || expire) begin
            state_q    <= ARB_IDLE;
            gnt_q      <= '0;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= '0;
            if (hold) tmo_q <= 1'b1;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  // Output drive: message mux gated by ownership so valid stays low when idle.
  always_comb begin
    bus_gnt     = gnt_q;
    bus_active  = (state_q == ARB_OWN);
    owner_id    = owner_q;
    timeout_err = tmo_q;
    bus_msg     = '0;
    if (state_q == ARB_OWN) bus_msg = bus_tx[owner_q];
  end

endmodule

// File: tb/tb_coh_req_bus_arbiter.sv
// Self-checking bench for coh_req_bus_arbiter.
// Behavioural ownership model plus directed scenarios.
module tb_coh_req_bus_arbiter;
  import cache_types::*;

  localparam int N   = 4;
  localparam int TMO = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   bus_req;
  req_msg_t       bus_tx [N];
  logic [N-1:0]   bus_busy;
  logic [N-1:0]   bus_gnt;
  req_msg_t       bus_msg;
  logic [1:0]     owner_id;
  logic           bus_active;
  logic           timeout_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  coh_req_bus_arbiter #(
    .NUM_CACHES (N),
    .TIMEOUT    (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus_req     (bus_req),
    .bus_tx      (bus_tx),
    .bus_busy    (bus_busy),
    .bus_gnt     (bus_gnt),
    .bus_msg     (bus_msg),
    .owner_id    (owner_id),
    .bus_active  (bus_active),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model: owner index (-1 idle), pointer, cycles owned, sticky error.
  int m_own = -1;
  int m_ptr = 0;
  int m_age = 0;
  bit m_err = 1'b0;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_own = -1;
      m_ptr = 0;
      m_age = 0;
      m_err = 1'b0;
    end else if (m_own < 0) begin
      m_own = pick(bus_req, m_ptr);
      m_age = 1;
    end else if (!(bus_req[m_own] || bus_busy != 0)) begin
      m_ptr = (m_own + 1) % N;
      m_own = -1;
    end else if (m_age == TMO) begin
      m_ptr = (m_own + 1) % N;
      m_own = -1;
      m_err = 1'b1;
    end else begin
      m_age++;
    end
  end

  always @(negedge clk) begin : cmp
    logic [N-1:0] eg;
    req_msg_t     em;
    if (chk_on) begin
      eg = '0;
      em = '0;
      if (m_own >= 0) begin
        eg[m_own] = 1'b1;
        em = bus_tx[m_own];
      end
      chk("gnt", 64'(bus_gnt), 64'(eg));
      chk("active", 64'(bus_active), 64'(m_own >= 0));
      if (m_own >= 0) chk("owner", 64'(owner_id), 64'(m_own));
      chk("msg", 64'(bus_msg), 64'(em));
      chk("terr", 64'(timeout_err), 64'(m_err));
      chk("onehot0", 64'($onehot0(bus_gnt)), 64'd1);
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst      = 1'b1;
    bus_req  = '0;
    bus_busy = '0;
    tick();
    rst = 1'b0;
  endtask

  logic [N-1:0] g [10];
  int n;

  initial begin
    for (int i = 0; i < N; i++) begin
      bus_tx[i].valid = 1'b1;
      bus_tx[i].cmd   = 3'(i + 1);
      bus_tx[i].addr  = 32'hA000_0000 + 32'(i * 16);
    end
    do_reset();
    chk_on = 1'b1;
    chk("rst gnt", 64'(bus_gnt), 64'd0);
    chk("rst owner", 64'(owner_id), 64'd0);
    chk("rst active", 64'(bus_active), 64'd0);
    chk("rst msg", 64'(bus_msg), 64'd0);
    chk("rst terr", 64'(timeout_err), 64'd0);

    // 1: single request from agent 2
    tick();
    bus_req = 4'b0100;
    tick();
    chk("t1 gnt", 64'(bus_gnt), 64'h4);
    chk("t1 owner", 64'(owner_id), 64'd2);
    chk("t1 msg", 64'(bus_msg), {28'd0, 1'b1, 3'd3, 32'hA000_0020});
    tick();
    tick();
    bus_req = 4'b0000;
    tick();
    chk("t1 drop", 64'(bus_gnt), 64'h0);
    chk("t1 ptr", 64'(m_ptr), 64'd3);

    // 2: all request, each owner keeps the bus one cycle
    do_reset();
    bus_req = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      tick();
      g[c] = bus_gnt;
      bus_req = ~bus_gnt;
    end
    bus_req = '0;
    for (int k = 0; k < 5; k++) begin
      chk("t2 order", 64'(g[2*k]), 64'(4'b0001 << (k % 4)));
      chk("t2 dead", 64'(g[2*k+1]), 64'd0);
    end
    tick();
    tick();

    // 3: owner 1 drops but a snooper stays busy
    do_reset();
    bus_req = 4'b0010;
    tick();
    chk("t3 gnt", 64'(bus_gnt), 64'h2);
    bus_req  = 4'b0000;
    bus_busy = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t3 held", 64'(bus_gnt), 64'h2);
    end
    bus_busy = 4'b0000;
    tick();
    chk("t3 rel", 64'(bus_gnt), 64'h0);

    // 4: watchdog forced release
    do_reset();
    bus_req = 4'b0011;
    tick();
    n = 0;
    while (bus_gnt == 4'b0001 && n < 20) begin
      n++;
      tick();
    end
    chk("t4 own cycles", 64'(n), 64'd8);
    chk("t4 rel gnt", 64'(bus_gnt), 64'h0);
    chk("t4 terr", 64'(timeout_err), 64'd1);
    tick();
    chk("t4 next gnt", 64'(bus_gnt), 64'h2);
    bus_req = 4'b0001;
    tick();
    tick();
    chk("t4 then 0", 64'(bus_gnt), 64'h1);
    bus_req = 4'b0000;
    tick();
    tick();
    chk("t4 sticky", 64'(timeout_err), 64'd1);

    // 5: reset in the middle of ownership
    do_reset();
    bus_req = 4'b1000;
    tick();
    chk("t5 gnt", 64'(bus_gnt), 64'h8);
    chk("t5 owner", 64'(owner_id), 64'd3);
    rst     = 1'b1;
    bus_req = 4'b1001;
    tick();
    chk("t5 rst gnt", 64'(bus_gnt), 64'h0);
    chk("t5 rst act", 64'(bus_active), 64'd0);
    chk("t5 ptr", 64'(m_ptr), 64'd0);
    rst = 1'b0;
    tick();
    chk("t5 first", 64'(bus_gnt), 64'h1);
    bus_req = 4'b0000;
    tick();
    tick();

    // 6: owner 2 re-requests at once, agent 1 waiting
    do_reset();
    bus_req = 4'b0100;
    tick();
    bus_req = 4'b0110;
    tick();
    chk("t6 own2", 64'(bus_gnt), 64'h4);
    bus_req = 4'b0010;
    tick();
    chk("t6 rel", 64'(bus_gnt), 64'h0);
    chk("t6 ptr", 64'(m_ptr), 64'd3);
    bus_req = 4'b0110;
    tick();
    chk("t6 fair", 64'(bus_gnt), 64'h2);
    bus_req = 4'b0100;
    tick();
    chk("t6 rel1", 64'(bus_gnt), 64'h0);
    tick();
    chk("t6 then 2", 64'(bus_gnt), 64'h4);
    bus_req = 4'b0000;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
